// File: rtl/argmax_sched.sv
// Symbol scheduler for the argmax datapath. It meters the lambda stream into whole N-sample windows.
// One theta per window is captured into a small result FIFO, and credit-based backpressure ensures no result is lost.
module argmax_sched #(
    parameter int N         = 256,
    parameter int RES_DEPTH = 2,
    parameter int SYMW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SYMW-1:0] num_sym,
    output logic            busy,
    output logic            done,
    input  logic            lam_valid,
    output logic            lam_ready,
    input  logic [15:0]     lam_data,
    output logic            minus_valid,
    output logic [15:0]     lambda,
    input  logic            argmax_valid,
    input  logic [7:0]      theta_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [7:0]      res_theta,
    output logic [SYMW-1:0] res_sym,
    output logic            err_unexp
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int OW = $clog2(RES_DEPTH * N + 1);
    localparam int PW = $clog2(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SYMW-1:0] num_sym_q, num_sym_d;
    logic [IW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [SYMW-1:0] iss_sym_q, iss_sym_d;
    logic [CW-1:0]   open_q, open_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [IW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [SYMW-1:0] cap_sym_q, cap_sym_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            minus_valid_q, minus_valid_d;
    logic [15:0]     lambda_q, lambda_d;
    logic            err_q, err_d;
    logic [7:0]      theta_mem_q [RES_DEPTH];
    logic [SYMW-1:0] sym_mem_q   [RES_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic accept, win_start, win_last, ret_ok, capture, push, pop;
    logic credit_ok, iss_sym_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A new window may only open when its theta is guaranteed a FIFO slot.
    assign credit_ok    = ({1'b0, open_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(RES_DEPTH);
    assign iss_sym_done = (iss_sym_q == num_sym_q) && (issue_cnt_q == '0);
    assign lam_ready    = (state_q == S_RUN) && !iss_sym_done && ((issue_cnt_q != '0) || credit_ok);

    assign accept    = lam_valid && lam_ready;
    assign win_start = accept && (issue_cnt_q == '0);
    assign win_last  = accept && (issue_cnt_q == IW'(N - 1));
    assign ret_ok    = argmax_valid && (outstanding_q != '0);
    assign capture   = ret_ok && (ret_cnt_q == IW'(N - 1));
    assign pop       = res_valid && res_ready;
    assign push      = capture && ((fifo_cnt_q != CW'(RES_DEPTH)) || pop);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        num_sym_d     = num_sym_q;
        issue_cnt_d   = issue_cnt_q;
        iss_sym_d     = iss_sym_q;
        cap_sym_d     = capture ? cap_sym_q + SYMW'(1) : cap_sym_q;
        ret_cnt_d     = ret_cnt_q;
        minus_valid_d = 1'b0;
        lambda_d      = lambda_q;
        done_d        = 1'b0;
        err_d         = err_q | (argmax_valid && (outstanding_q == '0));
        outstanding_d = outstanding_q + OW'(accept) - OW'(ret_ok);
        open_d        = open_q + CW'(win_start) - CW'(capture);
        fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        if (ret_ok) begin
            ret_cnt_d = (ret_cnt_q == IW'(N - 1)) ? '0 : ret_cnt_q + IW'(1);
        end

        if (accept) begin
            minus_valid_d = 1'b1;
            lambda_d      = lam_data;
            issue_cnt_d   = win_last ? '0 : issue_cnt_q + IW'(1);
            if (win_start) begin
                iss_sym_d = iss_sym_q + SYMW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue_cnt_d = '0;
                    iss_sym_d   = '0;
                    cap_sym_d   = '0;
                    if (num_sym == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        num_sym_d = num_sym;
                    end
                end
            end
            S_RUN: begin
                if (win_last && (iss_sym_q == num_sym_q)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // done lines up with the capture of the final theta, not one cycle after it.
                if (cap_sym_d == num_sym_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            num_sym_q     <= '0;
            issue_cnt_q   <= '0;
            iss_sym_q     <= '0;
            open_q        <= '0;
            outstanding_q <= '0;
            ret_cnt_q     <= '0;
            cap_sym_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            minus_valid_q <= 1'b0;
            lambda_q      <= '0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            // NOTE: the result storage is reset because its head entry is visible on res_theta/res_sym.
            for (int i = 0; i < RES_DEPTH; i++) begin
                theta_mem_q[i] <= '0;
                sym_mem_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            num_sym_q     <= num_sym_d;
            issue_cnt_q   <= issue_cnt_d;
            iss_sym_q     <= iss_sym_d;
            open_q        <= open_d;
            outstanding_q <= outstanding_d;
            ret_cnt_q     <= ret_cnt_d;
            cap_sym_q     <= cap_sym_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            minus_valid_q <= minus_valid_d;
            lambda_q      <= lambda_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (push) begin
                theta_mem_q[wr_ptr_q] <= theta_in;
                sym_mem_q[wr_ptr_q]   <= cap_sym_q;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign minus_valid = minus_valid_q;
    assign lambda      = lambda_q;
    assign err_unexp   = err_q;
    assign res_valid   = (fifo_cnt_q != '0);
    assign res_theta   = theta_mem_q[rd_ptr_q];
    assign res_sym     = sym_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_argmax_sched.sv
// Scoreboard bench for argmax_sched: a behavioural argmax model answers minus_valid pulses,
// expected {theta, sym} entries are queued at stimulus time and popped by an independent monitor.
module tb_argmax_sched;
    localparam int N    = 256;
    localparam int SYMW = 8;

    typedef struct {
        int th;
        int sym;
    } exp_t;

    logic            clk          = 1'b0;
    logic            rst          = 1'b1;
    logic            start        = 1'b0;
    logic [SYMW-1:0] num_sym      = '0;
    logic            lam_valid    = 1'b0;
    logic [15:0]     lam_data     = '0;
    logic            argmax_valid = 1'b0;
    logic [7:0]      theta_in     = '0;
    logic            res_ready    = 1'b1;
    logic            busy, done, lam_ready, minus_valid, res_valid, err_unexp;
    logic [15:0]     lambda;
    logic [7:0]      res_theta;
    logic [SYMW-1:0] res_sym;

    argmax_sched #(.N(N), .RES_DEPTH(2), .SYMW(SYMW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_sym     (num_sym),
        .busy        (busy),
        .done        (done),
        .lam_valid   (lam_valid),
        .lam_ready   (lam_ready),
        .lam_data    (lam_data),
        .minus_valid (minus_valid),
        .lambda      (lambda),
        .argmax_valid(argmax_valid),
        .theta_in    (theta_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_theta   (res_theta),
        .res_sym     (res_sym),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   frame_data[$];
    int   acc_cnt       = 0;
    int   last_hs_cyc   = 0;
    int   first_res_cyc = -1;
    int   done_cyc      = -1;
    int   mv_count      = 0;
    logic force_unexp   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Later sample wins on ties, index 0 is the first sample of the window.
    function automatic int best_index(input int v[$]);
        int bi = 0;
        for (int i = 1; i < v.size(); i++) begin
            if (v[i] >= v[bi]) bi = i;
        end
        return bi;
    endfunction

    // Behavioural argmax: answers each sample 9 cycles after minus_valid; only the
    // pulse closing a window carries a meaningful theta, the rest carry noise.
    int am_win[$];
    int am_due[$];
    int am_theta[$];
    always @(negedge clk) begin
        argmax_valid = 1'b0;
        if (rst) begin
            am_win.delete();
            am_due.delete();
            am_theta.delete();
        end else begin
            if (am_due.size() != 0 && am_due[0] == cyc) begin
                argmax_valid = 1'b1;
                theta_in     = 8'(am_theta[0]);
                void'(am_due.pop_front());
                void'(am_theta.pop_front());
            end
            if (force_unexp) argmax_valid = 1'b1;
            if (minus_valid) begin
                mv_count++;
                am_win.push_back(int'($signed(lambda)));
                am_due.push_back(cyc + 9);
                if (am_win.size() == N) begin
                    am_theta.push_back(best_index(am_win));
                    am_win.delete();
                end else begin
                    am_theta.push_back(int'($urandom_range(0, 255)));
                end
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got sym %0d theta %0d, expected no result", res_sym, res_theta);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_theta", int'(res_theta), mon_e.th);
                check("res_sym", int'(res_sym), mon_e.sym);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_lam_ready"}, int'(lam_ready), 0);
        check({tag, "_minus_valid"}, int'(minus_valid), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_err_unexp"}, int'(err_unexp), 0);
        check({tag, "_lambda"}, int'(lambda), 0);
        check({tag, "_res_theta"}, int'(res_theta), 0);
        check({tag, "_res_sym"}, int'(res_sym), 0);
    endtask

    task automatic fill_rand(input int ns);
        frame_data.delete();
        for (int i = 0; i < ns * N; i++) frame_data.push_back(int'($urandom_range(0, 40)) - 20);
    endtask

    task automatic push_exp_from_data(input int ns);
        int w[$];
        for (int s = 0; s < ns; s++) begin
            w.delete();
            for (int i = 0; i < N; i++) w.push_back(frame_data[s * N + i]);
            exp_q.push_back('{best_index(w), s});
        end
    endtask

    task automatic start_frame(input int ns);
        num_sym = SYMW'(ns);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int total, input int gap_pct);
        int   budget = 0;
        logic hs;
        acc_cnt = 0;
        while (acc_cnt < total && budget < 20000) begin
            lam_valid = (int'($urandom_range(0, 99)) >= gap_pct);
            lam_data  = 16'(frame_data[acc_cnt]);
            @(negedge clk);
            hs = lam_valid && lam_ready;
            if (hs) last_hs_cyc = cyc + 1;
            @(posedge clk);
            #1;
            if (hs) acc_cnt++;
            budget++;
        end
        lam_valid = 1'b0;
        if (acc_cnt < total) check("feed_timeout", acc_cnt, total);
    endtask

    task automatic wait_done(input int limit);
        int n   = 0;
        int got = 0;
        first_res_cyc = -1;
        done_cyc      = -1;
        while (got == 0 && n < limit) begin
            @(negedge clk);
            if (res_valid && first_res_cyc < 0) first_res_cyc = cyc;
            if (done) begin
                got      = 1;
                done_cyc = cyc;
            end
            n++;
        end
        check("done_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int ns, input int gap_pct);
        start_frame(ns);
        feed(ns * N, gap_pct);
        wait_done(400);
        drain(100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        int mv0;
        int n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_hold");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("rst_release");

        // Single window, peak at 100, with latency checks.
        frame_data.delete();
        for (int i = 0; i < N; i++) frame_data.push_back(i == 100 ? 500 : -100);
        exp_q.push_back('{100, 0});
        start_frame(1);
        check("run_busy", int'(busy), 1);
        feed(N, 0);
        wait_done(100);
        check("peak_res_latency", first_res_cyc - last_hs_cyc, 10);
        check("peak_done_latency", done_cyc - last_hs_cyc, 10);
        drain(100);

        // Ties: flat window then strictly decreasing ramp.
        frame_data.delete();
        for (int i = 0; i < N; i++) frame_data.push_back(7);
        for (int i = 0; i < N; i++) frame_data.push_back(1000 - i);
        exp_q.push_back('{255, 0});
        exp_q.push_back('{0, 1});
        run_frame(2, 0);

        // Random data, back-to-back windows.
        fill_rand(3);
        push_exp_from_data(3);
        run_frame(3, 0);

        // Same data gap-free and with 50% lam_valid duty.
        fill_rand(2);
        push_exp_from_data(2);
        run_frame(2, 0);
        push_exp_from_data(2);
        run_frame(2, 50);

        // Backpressure with res_ready held low.
        fill_rand(4);
        push_exp_from_data(4);
        res_ready = 1'b0;
        start_frame(4);
        fork
            feed(4 * N, 0);
            begin
                n = 0;
                while (acc_cnt < 2 * N && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (40) @(negedge clk);
                check("bp_accepted", acc_cnt, 2 * N);
                check("bp_lam_ready", int'(lam_ready), 0);
                check("bp_res_valid", int'(res_valid), 1);
                check("bp_head_sym", int'(res_sym), 0);
                check("bp_head_theta", int'(res_theta), exp_q[0].th);
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        wait_done(2000);
        drain(100);

        // num_sym = 0: quick done, no samples issued.
        mv0     = mv_count;
        num_sym = '0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("zero_done", got, 1);
        check("zero_no_samples", mv_count - mv0, 0);
        @(posedge clk);
        #1;

        // Unexpected argmax_valid while idle is sticky.
        check("err_before", int'(err_unexp), 0);
        force_unexp = 1'b1;
        @(posedge clk);
        #1;
        force_unexp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("err_set", int'(err_unexp), 1);
        repeat (10) @(posedge clk);
        #1;
        check("err_sticky", int'(err_unexp), 1);
        check("err_idle_busy", int'(busy), 0);

        // Reset in the middle of window 0.
        fill_rand(1);
        start_frame(1);
        feed(130, 0);
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Recovery run, peak at position 5.
        fill_rand(1);
        frame_data[5] = 1000;
        exp_q.push_back('{5, 0});
        run_frame(1, 0);

        check("final_exp_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_sched.md
# argmax_sched

Symbol scheduler for the argmax datapath. It accepts a frame command of `num_sym` symbols and meters the upstream lambda stream into argmax as exactly N samples per symbol window. It counts returning `argmax_valid` pulses, captures `theta` at the end of each window into a small result FIFO, and applies backpressure so that no window result can be lost.

## Interface
- N, 256, samples per symbol window. Must equal the argmax buffer depth.
- RES_DEPTH, 2, result FIFO entries. This is also the maximum number of windows open or pending.
- SYMW, 8, width of the symbol count and symbol index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clears all state
- start  in  1  frame start pulse; sampled only in IDLE
- num_sym  in  SYMW  symbols in the frame; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last symbol's theta is captured
- lam_valid  in  1  upstream lambda valid
- lam_ready  out  1  upstream lambda ready
- lam_data  in  16  lambda_t sample, signed
- minus_valid  out  1  to argmax; registered
- lambda  out  16  to argmax; registered copy of lam_data
- argmax_valid  in  1  from argmax
- theta_in  in  8  theta_t from argmax theta_out
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  downstream pop
- res_theta  out  8  theta of the head entry
- res_sym  out  SYMW  symbol index of the head entry (0-based)
- err_unexp  out  1  sticky flag: argmax_valid arrived with no issued sample outstanding

## Operation
- **FSM states:** IDLE, RUN, FLUSH, DONE.
- **IDLE:**
  - start with num_sym≠0: latch num_sym, clear counters, go to RUN.
  - start with num_sym=0: go to DONE, issue no samples.
- **RUN:**
  - Accept a sample on lam_valid&&lam_ready. The accepted sample drives minus_valid=1 and lambda=lam_data on the next cycle; otherwise minus_valid=0 and lambda holds.
  - issue_cnt counts 0..N-1 within the current window; iss_sym counts started windows.
  - lam_ready = RUN && iss_sym_done==0 && (issue_cnt≠0 || open+fifo_count<RES_DEPTH).
    - open = windows with first sample issued whose theta is not yet captured.
    - iss_sym_done is asserted once num_sym full windows have been issued.
  - After N×num_sym samples are accepted, go to FLUSH.
- **Return path (all states):**
  - ret_cnt counts argmax_valid pulses modulo N.
  - On the pulse where ret_cnt==N-1:
    - push {theta_in, cap_sym} into the FIFO;
    - increment cap_sym;
    - decrement open.
  - The credit rule guarantees the FIFO is never full at a push. Any overflow is a design error.
  - argmax_valid while outstanding==0 sets err_unexp and is otherwise ignored. outstanding = issued − returned samples.
- **FLUSH:** when cap_sym==num_sym, go to DONE.
- **DONE:** pulse done for one cycle, then go to IDLE. The FIFO keeps draining independently of the FSM.
- **Window integrity:** argmax never clears its buffer between windows. Exactly N samples per window is what makes every window independent, so partial windows are never issued.
- **Result semantics:**
  - theta 0 = first sample of the window; 255 = last sample.
  - On equal values, the later sample wins.
- **FIFO:**
  - Pop on res_valid&&res_ready.
  - Simultaneous push and pop is allowed and leaves the count unchanged.

## Timing
- **Reset values:** busy, done, lam_ready, minus_valid, res_valid, err_unexp = 0; lambda, res_theta, res_sym = 0; FSM = IDLE.
- **Path latencies:**
  - Handshake at edge t → minus_valid high during cycle t+1 → argmax_valid high 9 cycles later.
  - With an empty FIFO, res_valid rises in the cycle after edge t+10, where t is the handshake edge of the window's last sample.
- **Throughput:** one sample per cycle sustained. Back-to-back windows need no bubble when credit is available.
- **Stalls:** lam_valid gaps simply produce minus_valid=0 cycles; argmax holds its buffer, and the result is unaffected.
- **Credit stall:** lam_ready drops only at a window boundary (issue_cnt==0). It re-rises the cycle after a pop frees credit.
- **start during busy:** ignored.
- **Reset mid-operation:** everything returns to reset values within the same cycle, and in-flight results are discarded. argmax shares rst, so no stale argmax_valid follows.

## Test plan
- **Single window, peak at position 100:** num_sym=1; lambda = −100 everywhere except sample 100 = 500; res_ready=1.
  - Required: res_theta=100, res_sym=0.
  - res_valid 10 cycles after the last handshake; done pulses the same cycle the entry is captured.
- **Ties:** all 256 samples equal to 7 → theta=255. Strictly decreasing ramp → theta=0.
- **Backpressure:** num_sym=4 with res_ready held low.
  - Required: lam_ready drops at the start of window 2, after two windows are issued; FIFO holds sym 0 and 1.
  - Release res_ready; all four results then emerge in order 0..3 with their correct thetas.
- **Gapped input:** lam_valid random at 50% duty over num_sym=2 → thetas identical to the gap-free run.
- **Degenerate and illegal:**
  - start with num_sym=0 → done pulse within 2 cycles, no minus_valid.
  - argmax_valid forced while idle → err_unexp=1, stays 1 until rst.
- **Reset mid-window:** assert rst after 130 samples of window 0 → all outputs at reset values.
  - A following num_sym=1 run with peak at position 5 gives theta=5.
